// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding and widths for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W  = 4;
    localparam int WORD_W = 32;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous RAM with write enable and registered read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle MEM-stage load/store responder with fixed latency
// Optional misaligned-access flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               accept, commit;
    logic               err_in;
    logic               unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign err_in      = (addr_i[1:0] != 2'b00);
    assign unused_addr = ^addr_i[WORD_W-1:IDX_W+2];
`else
    assign err_in      = 1'b0;
    assign unused_addr = ^{addr_i[WORD_W-1:IDX_W+2], addr_i[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall_o = ((state_q == IDLE) && req_i) || (state_q == BUSY);

    // With LATENCY==1 the commit happens on the acceptance edge, before the latch is loaded.
    logic               c_we, c_err;
    logic [IDX_W-1:0]   c_idx;
    logic [WORD_W-1:0]  c_wdata;
    logic               from_in;

    assign from_in = (state_q == IDLE);
    assign c_we    = from_in ? we_i                : we_q;
    assign c_err   = from_in ? err_in              : err_q;
    assign c_idx   = from_in ? addr_i[IDX_W+1:2]   : idx_q;
    assign c_wdata = from_in ? wdata_i             : wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= commit;
            err_o   <= commit & c_err;
            if (accept) begin
                we_q    <= we_i;
                err_q   <= err_in;
                idx_q   <= addr_i[IDX_W+1:2];
                wdata_q <= wdata_i;
            end
        end
    end

    // Reset on the commit edge must win, so both ports are gated by rst_n_i.
    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we      (rst_n_i & commit & c_we & ~c_err),
        .re      (rst_n_i & commit & ~c_we),
        .rzero   (c_err),
        .idx     (c_idx),
        .wdata   (c_wdata),
        .rdata   (rdata_o)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 3 and 1 instances)
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int checks = 0;
    int passes = 0;

    dmem_responder #(.DEPTH(32), .LATENCY(3)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .stall_o(stall[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    dmem_responder #(.DEPTH(32), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .stall_o(stall[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passes++;
    endtask

    // Transaction-level model: an access accepted in cycle A acks in cycle A+LAT,
    // the block is free again from cycle A+LAT+1, and its effect is visible at the ack.
    function automatic int lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    int          cyc = 0;
    bit          model_ok = 0;
    bit          act   [2];
    int          acc   [2];
    bit          m_we  [2];
    bit          m_err [2];
    int          m_idx [2];
    logic [31:0] m_wd  [2];
    logic [31:0] m_rd  [2];
    logic [31:0] mmem  [2][32];

    function automatic bit m_idle(input int d);
        return !(act[d] && cyc <= acc[d] + lat(d));
    endfunction

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                act[d]  = 0;
                m_rd[d] = 32'h0;
            end else begin
                if (m_idle(d) && req[d]) begin
                    act[d]  = 1;
                    acc[d]  = cyc;
                    m_we[d] = we[d];
                    m_idx[d] = int'(addr[d][6:2]);
                    m_wd[d] = wdata[d];
`ifdef DMEM_ALIGN_CHECK_EN
                    m_err[d] = (addr[d][1:0] != 2'b00);
`else
                    m_err[d] = 0;
`endif
                end
                if (act[d] && cyc == acc[d] + lat(d) - 1) begin
                    if (m_we[d]) begin
                        if (!m_err[d]) mmem[d][m_idx[d]] = m_wd[d];
                    end else begin
                        m_rd[d] = m_err[d] ? 32'h0 : mmem[d][m_idx[d]];
                    end
                end
            end
        end
        if (!rst_n) model_ok = 1;
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            for (int d = 0; d < 2; d++) begin
                bit ea, es;
                ea = act[d] && (cyc == acc[d] + lat(d));
                es = (m_idle(d) && req[d]) || (act[d] && cyc < acc[d] + lat(d));
                chk($sformatf("stall%0d@%0d", d, cyc), 32'(stall[d]), 32'(es));
                chk($sformatf("ack%0d@%0d", d, cyc), 32'(ack[d]), 32'(ea));
                chk($sformatf("err%0d@%0d", d, cyc), 32'(err[d]), 32'(ea && m_err[d]));
                chk($sformatf("rdata%0d@%0d", d, cyc), rdata[d], m_rd[d]);
            end
        end
    end

    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                          output int lat_seen, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dat;
        lat_seen = -1;
        rd = 32'hx;
        er = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin
                lat_seen = k;
                rd = rdata[d];
                er = err[d];
                break;
            end
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    int          ls;
    logic [31:0] rd;
    logic        er;
    int          nack;
    logic [3:0]  ackv, stv;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle rdata", rdata[0], 32'h0);
        chk("idle ack", 32'(ack[0]), 32'h0);

        access(0, 1'b1, 32'h8, 32'hDEADBEEF, ls, rd, er);
        chk("store lat", 32'(ls), 32'd3);
        access(0, 1'b0, 32'h8, 32'h0, ls, rd, er);
        chk("load lat", 32'(ls), 32'd3);
        chk("load data", rd, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        chk("load held", rdata[0], 32'hDEADBEEF);

        access(0, 1'b1, 32'h84, 32'h12345678, ls, rd, er);
        access(0, 1'b0, 32'h04, 32'h0, ls, rd, er);
        chk("wrap load", rd, 32'h12345678);

        access(0, 1'b1, 32'h10, 32'h0, ls, rd, er);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hAAAA5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack[0]) nack++;
        end
        chk("abort no ack", 32'(nack), 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, ls, rd, er);
        chk("abort no write", rd, 32'h0);

        access(1, 1'b1, 32'h0, 32'hCAFEF00D, ls, rd, er);
        chk("lat1 store lat", 32'(ls), 32'd1);
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ackv[k] = ack[1];
            stv[k]  = stall[1];
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("b2b ack", 32'(ackv), 32'b1010);
        chk("b2b stall", 32'(stv), 32'b0101);
        chk("b2b rdata", rdata[1], 32'hCAFEF00D);

        access(0, 1'b1, 32'h0A, 32'h0BADBAD0, ls, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis store err", 32'(er), 32'd1);
        access(0, 1'b0, 32'h08, 32'h0, ls, rd, er);
        chk("mis store blocked", rd, 32'hDEADBEEF);
        access(0, 1'b0, 32'h0A, 32'h0, ls, rd, er);
        chk("mis load data", rd, 32'h0);
        chk("mis load err", 32'(er), 32'd1);
        chk("mis load lat", 32'(ls), 32'd3);
`else
        chk("mis store err", 32'(er), 32'd0);
        access(0, 1'b0, 32'h08, 32'h0, ls, rd, er);
        chk("mis store word2", rd, 32'h0BADBAD0);
        access(0, 1'b0, 32'h0A, 32'h0, ls, rd, er);
        chk("mis load data", rd, 32'h0BADBAD0);
        chk("mis load err", 32'(er), 32'd0);
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
